// File: rtl/hyst_pkg.sv
// Shared default constants for the hysteresis selector and its helpers.
package hyst_pkg;

  // Default sensor width, channel count, hysteresis margin and dwell length.
  localparam int HYST_W     = 8;
  localparam int HYST_N     = 4;
  localparam int HYST_TH    = 10;
  localparam int HYST_DWELL = 4;

endpackage : hyst_pkg

// File: rtl/hyst_argmax.sv
// Combinational N-way maximum finder. One channel (excl) is skipped, and ties
// resolve to the lowest index because only a strictly larger value replaces
// the running best.
module hyst_argmax
  import hyst_pkg::*;
#(
  parameter int W    = HYST_W,
  parameter int N    = HYST_N,
  parameter int IDXW = $clog2(HYST_N)
) (
  input  logic [N*W-1:0]  ts,
  input  logic [IDXW-1:0] excl,
  output logic [IDXW-1:0] idx,
  output logic [W-1:0]    val
);

  logic found;

  // Linear scan over all channels except the excluded one.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and no latch is inferred.
    found = 1'b0;
    idx   = '0;
    val   = '0;
    for (int i = 0; i < N; i++) begin
      if (IDXW'(i) != excl) begin
        if (!found || (ts[i*W +: W] > val)) begin
          found = 1'b1;
          idx   = IDXW'(i);
          val   = ts[i*W +: W];
        end
      end
    end
  end

endmodule : hyst_argmax

// File: rtl/hyst_sel.sv
// N-channel hysteresis selector with dwell. Tracks the leading (highest)
// sensor; the leader only changes once a single challenger beats it by more
// than TH for DWELL consecutive valid samples. All outputs are registered.
module hyst_sel
  import hyst_pkg::*;
#(
  parameter int W     = HYST_W,
  parameter int N     = HYST_N,
  parameter int TH    = HYST_TH,
  parameter int DWELL = HYST_DWELL,
  localparam int IDXW = $clog2(N),
  localparam int CW   = $clog2(DWELL + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_valid,
  input  logic [N*W-1:0]  ts,
  output logic [IDXW-1:0] sel,
  output logic [N-1:0]    sel_onehot,
  output logic            switch_pulse,
  output logic [CW-1:0]   dwell_cnt
);

  logic [IDXW-1:0] cand;
  logic [IDXW-1:0] c_idx;
  logic [W-1:0]    c_val;
  logic [W-1:0]    sel_val;
  logic            beat;
  logic [CW-1:0]   next_cnt;

  logic [IDXW-1:0] sel_d;
  logic [N-1:0]    onehot_d;
  logic            pulse_d;
  logic [CW-1:0]   cnt_d;
  logic [IDXW-1:0] cand_d;

  // Strongest channel other than the current leader.
  hyst_argmax #(
    .W    (W),
    .N    (N),
    .IDXW (IDXW)
  ) u_argmax (
    .ts   (ts),
    .excl (sel),
    .idx  (c_idx),
    .val  (c_val)
  );

  assign sel_val = ts[sel*W +: W];

  // Margin compare one bit wider than the readings so leader+TH cannot wrap;
  // equality with leader+TH is not a beat.
  assign beat = {1'b0, c_val} > ({1'b0, sel_val} + (W+1)'(TH));

  // The count continues only for the same candidate in an unbroken run.
  assign next_cnt = ((c_idx == cand) && (dwell_cnt != '0)) ? dwell_cnt + 1'b1 : CW'(1);

  // Next-state decision: hold on invalid samples, clear on a non-beat,
  // count or switch on a beat.
  always_comb begin
    sel_d    = sel;
    onehot_d = sel_onehot;
    pulse_d  = 1'b0;
    cnt_d    = dwell_cnt;
    cand_d   = cand;
    if (sample_valid) begin
      if (beat) begin
        cand_d = c_idx;
        if (next_cnt == CW'(DWELL)) begin
          sel_d           = c_idx;
          onehot_d        = '0;
          onehot_d[c_idx] = 1'b1;
          pulse_d         = 1'b1;
          cnt_d           = '0;
        end else begin
          cnt_d = next_cnt;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // State and output registers; synchronous reset takes priority over samples.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      sel          <= '0;
      sel_onehot   <= N'(1);
      switch_pulse <= 1'b0;
      dwell_cnt    <= '0;
      cand         <= '0;
    end else begin
      sel          <= sel_d;
      sel_onehot   <= onehot_d;
      switch_pulse <= pulse_d;
      dwell_cnt    <= cnt_d;
      cand         <= cand_d;
    end
  end

endmodule : hyst_sel

// File: tb/tb_hyst_sel.sv
// Directed bench for hyst_sel: default build (DWELL=4) plus a DWELL=1 build
// sharing the same stimulus.
module tb_hyst_sel;
  import hyst_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [31:0] ts = '0;

  logic [1:0]  sel;
  logic [3:0]  sel_onehot;
  logic        switch_pulse;
  logic [2:0]  dwell_cnt;

  logic [1:0]  sel1;
  logic [3:0]  sel_onehot1;
  logic        switch_pulse1;
  logic [0:0]  dwell_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hyst_sel #(.W(8), .N(4), .TH(10), .DWELL(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .ts           (ts),
    .sel          (sel),
    .sel_onehot   (sel_onehot),
    .switch_pulse (switch_pulse),
    .dwell_cnt    (dwell_cnt)
  );

  hyst_sel #(.W(8), .N(4), .TH(10), .DWELL(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .ts           (ts),
    .sel          (sel1),
    .sel_onehot   (sel_onehot1),
    .switch_pulse (switch_pulse1),
    .dwell_cnt    (dwell_cnt1)
  );

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Advance one edge; outputs are read 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] t);
    sample_valid = v;
    ts           = t;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b1;
    ts = pack(200, 10, 90, 30);
    repeat (2) step();
    rst = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d exp 0", sel); end
    checks++; if (sel_onehot !== 4'b0001) begin errors++; $display("FAIL reset_onehot: got %b exp 0001", sel_onehot); end
    checks++; if (switch_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b exp 0", switch_pulse); end
    checks++; if (dwell_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", dwell_cnt); end
  endtask

  task automatic test_basic_switch();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, pack(50, 40, 61, 40));
      checks++; if (dwell_cnt !== 3'(k)) begin errors++; $display("FAIL basic_cnt%0d: got %0d exp %0d", k, dwell_cnt, k); end
      checks++; if (sel !== 2'd0 || switch_pulse !== 1'b0) begin errors++; $display("FAIL basic_hold%0d: sel %0d pulse %b exp 0/0", k, sel, switch_pulse); end
    end
    drive(1'b1, pack(50, 40, 61, 40));
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL basic_sel: got %0d exp 2", sel); end
    checks++; if (sel_onehot !== 4'b0100) begin errors++; $display("FAIL basic_onehot: got %b exp 0100", sel_onehot); end
    checks++; if (switch_pulse !== 1'b1) begin errors++; $display("FAIL basic_pulse: got %b exp 1", switch_pulse); end
    checks++; if (dwell_cnt !== 3'd0) begin errors++; $display("FAIL basic_cnt_clear: got %0d exp 0", dwell_cnt); end
    drive(1'b1, pack(50, 40, 61, 40));
    checks++; if (switch_pulse !== 1'b0 || sel !== 2'd2) begin errors++; $display("FAIL basic_pulse_once: pulse %b sel %0d exp 0/2", switch_pulse, sel); end
  endtask

  task automatic test_boundary();
    do_reset();
    repeat (6) drive(1'b1, pack(50, 40, 60, 40));
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL bound_sel: got %0d exp 0", sel); end
    checks++; if (dwell_cnt !== 3'd0) begin errors++; $display("FAIL bound_cnt: got %0d exp 0", dwell_cnt); end
  endtask

  // Switch to ch2, then the old leader ch0 must win by more than TH to return.
  task automatic test_back_to_back();
    do_reset();
    repeat (4) drive(1'b1, pack(50, 40, 61, 40));
    repeat (3) drive(1'b1, pack(71, 40, 61, 40));
    checks++; if (sel !== 2'd2 || dwell_cnt !== 3'd0) begin errors++; $display("FAIL b2b_eq: sel %0d cnt %0d exp 2/0", sel, dwell_cnt); end
    drive(1'b1, pack(72, 40, 61, 40));
    checks++; if (dwell_cnt !== 3'd1) begin errors++; $display("FAIL b2b_cnt: got %0d exp 1", dwell_cnt); end
    repeat (3) drive(1'b1, pack(72, 40, 61, 40));
    checks++; if (sel !== 2'd0 || switch_pulse !== 1'b1) begin errors++; $display("FAIL b2b_return: sel %0d pulse %b exp 0/1", sel, switch_pulse); end
  endtask

  task automatic test_interruption();
    do_reset();
    repeat (3) drive(1'b1, pack(50, 70, 40, 40));
    checks++; if (dwell_cnt !== 3'd3) begin errors++; $display("FAIL intr_pre: got %0d exp 3", dwell_cnt); end
    drive(1'b1, pack(50, 55, 40, 40));
    checks++; if (dwell_cnt !== 3'd0) begin errors++; $display("FAIL intr_clear: got %0d exp 0", dwell_cnt); end
    repeat (3) drive(1'b1, pack(50, 70, 40, 40));
    checks++; if (sel !== 2'd0 || dwell_cnt !== 3'd3) begin errors++; $display("FAIL intr_wait: sel %0d cnt %0d exp 0/3", sel, dwell_cnt); end
    drive(1'b1, pack(50, 70, 40, 40));
    checks++; if (sel !== 2'd1 || switch_pulse !== 1'b1) begin errors++; $display("FAIL intr_switch: sel %0d pulse %b exp 1/1", sel, switch_pulse); end
  endtask

  task automatic test_candidate_change();
    do_reset();
    repeat (2) drive(1'b1, pack(50, 70, 40, 40));
    drive(1'b1, pack(50, 70, 40, 80));
    checks++; if (dwell_cnt !== 3'd1) begin errors++; $display("FAIL cand_restart: got %0d exp 1", dwell_cnt); end
    repeat (2) drive(1'b1, pack(50, 70, 40, 80));
    checks++; if (sel !== 2'd0 || dwell_cnt !== 3'd3) begin errors++; $display("FAIL cand_wait: sel %0d cnt %0d exp 0/3", sel, dwell_cnt); end
    drive(1'b1, pack(50, 70, 40, 80));
    checks++; if (sel !== 2'd3 || sel_onehot !== 4'b1000) begin errors++; $display("FAIL cand_switch: sel %0d onehot %b exp 3/1000", sel, sel_onehot); end
    // Tie between ch1 and ch3 resolves to the lower index.
    do_reset();
    repeat (4) drive(1'b1, pack(50, 80, 40, 80));
    checks++; if (sel !== 2'd1 || sel_onehot !== 4'b0010) begin errors++; $display("FAIL tie_sel: sel %0d onehot %b exp 1/0010", sel, sel_onehot); end
  endtask

  task automatic test_width_edges();
    do_reset();
    repeat (4) drive(1'b1, pack(5, 15, 0, 0));
    checks++; if (sel !== 2'd0 || dwell_cnt !== 3'd0) begin errors++; $display("FAIL low_eq: sel %0d cnt %0d exp 0/0", sel, dwell_cnt); end
    repeat (4) drive(1'b1, pack(5, 16, 0, 0));
    checks++; if (sel !== 2'd1 || switch_pulse !== 1'b1) begin errors++; $display("FAIL low_switch: sel %0d pulse %b exp 1/1", sel, switch_pulse); end
    do_reset();
    repeat (4) drive(1'b1, pack(250, 255, 0, 0));
    checks++; if (sel !== 2'd0 || dwell_cnt !== 3'd0) begin errors++; $display("FAIL high_nowrap: sel %0d cnt %0d exp 0/0", sel, dwell_cnt); end
  endtask

  task automatic test_gaps();
    do_reset();
    drive(1'b1, pack(50, 40, 61, 40));
    repeat (2) drive(1'b0, pack(50, 40, 40, 40));
    checks++; if (dwell_cnt !== 3'd1) begin errors++; $display("FAIL gap_hold1: got %0d exp 1", dwell_cnt); end
    drive(1'b1, pack(50, 40, 61, 40));
    drive(1'b0, pack(50, 40, 61, 40));
    checks++; if (dwell_cnt !== 3'd2 || switch_pulse !== 1'b0) begin errors++; $display("FAIL gap_hold2: cnt %0d pulse %b exp 2/0", dwell_cnt, switch_pulse); end
    repeat (2) drive(1'b1, pack(50, 40, 61, 40));
    checks++; if (sel !== 2'd2 || switch_pulse !== 1'b1) begin errors++; $display("FAIL gap_switch: sel %0d pulse %b exp 2/1", sel, switch_pulse); end
    drive(1'b0, pack(50, 40, 61, 40));
    checks++; if (switch_pulse !== 1'b0) begin errors++; $display("FAIL gap_pulse_drop: got %b exp 0", switch_pulse); end
  endtask

  task automatic test_reset_mid_dwell();
    do_reset();
    repeat (3) drive(1'b1, pack(50, 40, 61, 40));
    checks++; if (dwell_cnt !== 3'd3) begin errors++; $display("FAIL rstmid_pre: got %0d exp 3", dwell_cnt); end
    rst = 1'b1;
    drive(1'b1, pack(50, 40, 61, 40));
    checks++; if (sel !== 2'd0 || sel_onehot !== 4'b0001) begin errors++; $display("FAIL rstmid_sel: sel %0d onehot %b exp 0/0001", sel, sel_onehot); end
    checks++; if (dwell_cnt !== 3'd0 || switch_pulse !== 1'b0) begin errors++; $display("FAIL rstmid_cnt: cnt %0d pulse %b exp 0/0", dwell_cnt, switch_pulse); end
    rst = 1'b0;
    drive(1'b1, pack(50, 40, 61, 40));
    checks++; if (dwell_cnt !== 3'd1) begin errors++; $display("FAIL rstmid_restart: got %0d exp 1", dwell_cnt); end
  endtask

  task automatic test_dwell1();
    do_reset();
    checks++; if (sel1 !== 2'd0 || sel_onehot1 !== 4'b0001) begin errors++; $display("FAIL d1_reset: sel %0d onehot %b exp 0/0001", sel1, sel_onehot1); end
    drive(1'b1, pack(50, 40, 61, 40));
    checks++; if (sel1 !== 2'd2 || sel_onehot1 !== 4'b0100) begin errors++; $display("FAIL d1_switch: sel %0d onehot %b exp 2/0100", sel1, sel_onehot1); end
    checks++; if (switch_pulse1 !== 1'b1 || dwell_cnt1 !== 1'b0) begin errors++; $display("FAIL d1_pulse: pulse %b cnt %0d exp 1/0", switch_pulse1, dwell_cnt1); end
    drive(1'b1, pack(50, 40, 61, 40));
    checks++; if (switch_pulse1 !== 1'b0 || sel1 !== 2'd2) begin errors++; $display("FAIL d1_settle: pulse %b sel %0d exp 0/2", switch_pulse1, sel1); end
  endtask

  initial begin
    test_reset();
    test_basic_switch();
    test_boundary();
    test_back_to_back();
    test_interruption();
    test_candidate_change();
    test_width_edges();
    test_gaps();
    test_reset_mid_dwell();
    test_dwell1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hyst_sel
